// File: rtl/mem_line_responder.sv
// mem_line_responder
//   Line-oriented memory model that answers one request at a time after a
//   fixed latency. Reads return a whole 32-byte line; writes update a single
//   byte and return the updated line.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   BUSY  | counting down the latency for the captured request
//   RESP  | resp_valid pulse; resp_line holds the result
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : request present
//   req_rw        : 0 = line read, 1 = byte write
//   req_addr      : byte address (line = [10:5], offset = [4:0])
//   req_wdata     : write byte
//   req_ready     : high only in IDLE
//   resp_valid    : one-cycle response pulse
//   resp_line     : 32-byte response line, byte k = mem[{line,k}]
//   busy          : high in BUSY and RESP
//   read_count    : completed line reads (wraps)
//   write_count   : completed byte writes (wraps)
module mem_line_responder #(
  parameter int LATENCY    = 100,
  parameter int LINE_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [10:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [7:0]  resp_line [0:LINE_BYTES-1],
  output logic        busy,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  // The terminal-count cycle itself performs the operation, so the counter
  // starts one short of the latency.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        cap_rw;
  logic [10:0] cap_addr;
  logic [7:0]  cap_wdata;
  logic [7:0]  mem [0:2047];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_rw      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
      for (int k = 0; k < LINE_BYTES; k++) resp_line[k] <= '0;
      for (int a = 0; a < 2048; a++) mem[a] <= 8'hE0 + {3'b000, a[4:0]};
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cap_rw    <= req_rw;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (cap_rw) begin
              mem[cap_addr] <= cap_wdata;
              write_count   <= write_count + 32'd1;
            end else begin
              read_count <= read_count + 32'd1;
            end
            // The written byte is forwarded so the response already reflects it.
            for (int k = 0; k < LINE_BYTES; k++) begin
              if (cap_rw && (cap_addr[4:0] == 5'(k)))
                resp_line[k] <= cap_wdata;
              else
                resp_line[k] <= mem[{cap_addr[10:5], 5'(k)}];
            end
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 Parameter LATENCY, default 100: cycles from request acceptance to response, legal range 1..255.
REQ-002 Parameter LINE_BYTES, default 32: bytes per line; fixed at 32, the only supported value.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 req_valid  input  1: request present this cycle.
REQ-006 req_rw  input  1: 0 = line read, 1 = byte write.
REQ-007 req_addr  input  11: byte address; line = req_addr[10:5], offset = req_addr[4:0].
REQ-008 req_wdata  input  8: write byte, used when req_rw = 1.
REQ-009 req_ready  output  1: high only in IDLE; request accepted on an edge where req_valid && req_ready.
REQ-010 resp_valid  output  1: one-cycle pulse, response line valid.
REQ-011 resp_line  output  8 x [0:31] (unpacked byte array, same shape as the cache's iRAM32 port): line data, byte k = mem[{line,k}].
REQ-012 busy  output  1: high in BUSY and RESP.
REQ-013 read_count  output  32: completed line reads.
REQ-014 write_count  output  32: completed byte writes.

Function
REQ-015 Storage: 2048 x 8 bytes; reset pattern mem[a] = 8'hE0 + a[4:0] for every a.
REQ-016 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-017 IDLE: on accept, capture req_rw/req_addr/req_wdata and load an 8-bit counter with LATENCY-1; go to BUSY; otherwise stay.
REQ-018 BUSY: counter nonzero -> decrement; counter zero -> perform operation, go to RESP.
REQ-019 Operation read: latch the 32 bytes of the captured line into resp_line; read_count += 1.
REQ-020 Operation write: mem[captured addr] <= captured wdata; resp_line latches the line including the new byte; write_count += 1.
REQ-021 RESP: resp_valid = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Timing: request accepted at edge N -> resp_valid high in the cycle after edge N+LATENCY; req_ready returns high one cycle later.
REQ-023 Back-to-back: minimum spacing between accepts is LATENCY+2 edges; no pipelining, single outstanding request.
REQ-024 Requests presented while req_ready = 0 are ignored (not queued); the requester holds req_valid until accepted.
REQ-025 Request inputs change during BUSY: no effect; only captured values are used.
REQ-026 resp_line holds its last value until the next operation completes; it is meaningful only while resp_valid is high.
REQ-027 Counters wrap modulo 2^32 with no saturation.
REQ-028 LATENCY = 1: BUSY lasts one cycle, response in cycle after edge N+1.

Reset
REQ-029 On rst assertion, immediately: state IDLE, resp_valid 0, busy 0, read_count 0, write_count 0, resp_line all 0, storage restored to REQ-015 pattern.
REQ-030 req_ready = 1 once rst deasserts; the first accept is possible on the first edge after deassertion.
REQ-031 Reset mid-operation aborts the request: no response, no memory update, no count increment.

Verification
REQ-032 Read line 5 (addr 11'h0A0), LATENCY=4 -> resp_valid in cycle after accept edge+4; resp_line[k] = E0+k for k=0..31; read_count 1.
REQ-033 Write addr 11'h0A3 data 8'h5A, then read addr 11'h0A0 -> write resp_line[3] = 5A; read resp_line[3] = 5A, others E0+k; write_count 1, read_count 1.
REQ-034 Hold req_valid continuously with changing addresses during BUSY -> exactly one response per LATENCY+2 edges, each for the address present at its accept edge.
REQ-035 Assert rst 2 cycles into a write to 11'h7FF -> no resp_valid pulse; subsequent read of line 63 returns E0..FF; counts 0 after the read except read_count 1.
REQ-036 LATENCY=1: read of line 0 -> resp_valid in cycle after accept edge+1; busy high for exactly 2 cycles.
REQ-037 Cache integration: drive the 4-way cache fill sequence through this block as its line source -> cache sees E0+k line data and miss penalty equals LATENCY+1 cycles per miss.
